md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core, attached to the E stage.
- Accepts mult/multu/div/divu with a fixed latency, and services mthi/mtlo/mfhi/mflo.
- Drives busy and a D-stage stall request, so the hazard logic blocks any MD-class instruction while an operation is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal 1..31
- DIV_CYCLES, 10, busy cycles for div/divu; legal 1..31

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- md_op  input  4  E-stage MD operation code (package encoding)
- start  input  1  E-stage valid strobe for md_op (low when E holds a bubble)
- a  input  32  E-stage rs value (forwarded)
- b  input  32  E-stage rt value (forwarded)
- d_is_md  input  1  D-stage instruction is MD-class (any nonzero md_op)
- busy  output  1  operation in flight
- stall  output  1  D-stage stall request
- out  output  32  HI for MFHI, LO for MFLO, else 0 (combinational)

Behaviour:
- Reset: HI=0, LO=0, cnt=0, state IDLE, busy=0, stall=0. Reset mid-operation discards the pending result.
- States: IDLE, BUSY.
- IDLE -> BUSY: on an edge with start=1 and md_op in {MULT, MULTU, DIV, DIVU}.
  - The result is computed from a/b sampled at that edge and held in internal pending_hi/pending_lo.
  - cnt loads MULT_CYCLES or DIV_CYCLES.
- BUSY: busy=1; cnt decrements each edge. At the edge where cnt goes 1->0: HI/LO <= pending, state -> IDLE.
- Latency: accept at edge E0; busy=1 for exactly N cycles; HI/LO visible on out in the first cycle busy=0.
- Arithmetic:
  - MULT: signed 32x32->64; HI=upper, LO=lower.
  - MULTU: unsigned 32x32->64.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (b=0, DIV/DIVU): full busy period still runs; HI/LO keep their previous values.
- MTHI/MTLO: with start=1 in IDLE, HI or LO <= a at the edge; no busy.
- MFHI/MFLO: pure combinational read, no state change.
- stall = d_is_md & (busy | (start & md_op is MULT/MULTU/DIV/DIVU)).
- Protocol violation (start while BUSY, any op): ignored. The pending result still commits; HI/LO are not written by MTHI/MTLO.
- Out-of-range md_op values: treated as NONE.

Optional Feature:
- MD_MADD_EN defined:
  - Adds MADD, MADDU, MSUB, MSUBU, with MULT_CYCLES latency.
  - pending = {HI,LO} ± product (64-bit wrap), using HI/LO as sampled at the accept edge.
- MD_MADD_EN undefined: these encodings are treated as NONE and never set busy.

Decomposition:
- Package md_pkg holds:
  - md_op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12
  - MD_WIDTH=32
  - helper constant CNT_W=5
- Sub-module md_latency_cnt:
  - load/decrement counter with done pulse; parameterised width.
- md_unit holds the FSM, arithmetic, HI/LO and stall logic.

Test Plan:
- MULT a=0xFFFFFFFF, b=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=2 -> LO=3, HI=1. Then DIV with b=0 -> HI/LO stay 1/3 after 10 busy cycles.
- MULT accepted with d_is_md=1 throughout -> stall=1 in the accept cycle and all 5 busy cycles, 0 afterwards. Also with d_is_md=0 -> stall=0 while busy=1.
- MTHI a=0x12345678, then MFHI next cycle -> out=0x12345678. Reset asserted mid-DIV -> busy=0, HI=LO=0 next cycle, no late commit. With MD_MADD_EN: HI:LO=0:5, MADD 3*4 -> LO=17.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e     : E-stage MD operation encodings (4-bit)
//   - md_state_e  : md_unit FSM states
//   - MD_WIDTH    : datapath width
//   - CNT_W       : latency counter width (covers 1..31 cycles)
//   - md_is_long  : op occupies the unit for a multi-cycle busy period
//   - md_is_div   : op uses the divide latency
// Optional feature macro: MD_MADD_EN (enables the madd/msub family).
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_long(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_latency_cnt.sv
// md_latency_cnt: load/decrement down-counter with a done pulse.
// Ports:
//   clk_i      : rising-edge clock
//   reset_i    : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i at the next edge (has priority)
//   load_val_i : value to load
//   dec_i      : decrement at the next edge (saturates at 0)
//   done_o     : high in the cycle whose closing edge takes the count 1 -> 0
module md_latency_cnt #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = dec_i & ~load_i & (cnt_q == WIDTH'(1));

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers, attached
// to the E stage of the pipelined MIPS core.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset
//   md_op   : E-stage MD operation (md_pkg::md_op_e encoding)
//   start   : E-stage valid strobe for md_op
//   a, b    : E-stage rs / rt values (forwarded)
//   d_is_md : D-stage instruction is MD-class
//   busy    : multi-cycle operation in flight (registered)
//   stall   : D-stage stall request
//   out     : HI for MFHI, LO for MFLO, else 0 (combinational)
// Parameters: MULT_CYCLES (1..31), DIV_CYCLES (1..31).
// Optional feature macro: MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          md_op,
  input  logic                start,
  input  logic [MD_WIDTH-1:0] a,
  input  logic [MD_WIDTH-1:0] b,
  input  logic                d_is_md,
  output logic                busy,
  output logic                stall,
  output logic [MD_WIDTH-1:0] out
);

  md_state_e           state_q;
  logic                busy_q;
  logic [MD_WIDTH-1:0] hi_q, lo_q;
  logic [MD_WIDTH-1:0] pend_hi_q, pend_lo_q;
  logic                pend_wr_q;
  logic [MD_WIDTH-1:0] pend_hi_d, pend_lo_d;
  logic                pend_wr_d;

  logic                accept;
  logic                cnt_done;
  logic [CNT_W-1:0]    cnt_load;

  // Products: operands extended to 64 bits so the low 64 bits of the
  // product are the exact signed / unsigned result.
  logic [2*MD_WIDTH-1:0] prod_s, prod_u;
  assign prod_s = {{MD_WIDTH{a[MD_WIDTH-1]}}, a} * {{MD_WIDTH{b[MD_WIDTH-1]}}, b};
  assign prod_u = {{MD_WIDTH{1'b0}}, a} * {{MD_WIDTH{1'b0}}, b};

  // One unsigned divider serves both DIV and DIVU: signed division works on
  // magnitudes and fixes up signs afterwards (quotient negative when signs
  // differ, remainder follows the dividend).
  logic                div_sgn;
  logic [MD_WIDTH-1:0] dvd, dvs, dvs_safe, quo, rem, q_res, r_res;
  assign div_sgn  = (md_op == MD_DIV);
  assign dvd      = (div_sgn && a[MD_WIDTH-1]) ? -a : a;
  assign dvs      = (div_sgn && b[MD_WIDTH-1]) ? -b : b;
  assign dvs_safe = (dvs == '0) ? MD_WIDTH'(1) : dvs;
  assign quo      = dvd / dvs_safe;
  assign rem      = dvd % dvs_safe;
  assign q_res    = (div_sgn && (a[MD_WIDTH-1] ^ b[MD_WIDTH-1])) ? -quo : quo;
  assign r_res    = (div_sgn && a[MD_WIDTH-1]) ? -rem : rem;

  always_comb begin
    pend_hi_d = '0;
    pend_lo_d = '0;
    pend_wr_d = 1'b1;
    case (md_op)
      MD_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
      MD_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
      MD_DIV, MD_DIVU: begin
        pend_hi_d = r_res;
        pend_lo_d = q_res;
        // Divide by zero still runs the busy period but leaves HI/LO alone.
        pend_wr_d = (b != '0);
      end
`ifdef MD_MADD_EN
      MD_MADD:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
      MD_MADDU: {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
      MD_MSUB:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_s;
      MD_MSUBU: {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_u;
`endif
      default: ;
    endcase
  end

  assign accept   = start && (state_q == MD_IDLE) && md_is_long(md_op);
  assign cnt_load = md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  md_latency_cnt #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (accept),
    .load_val_i (cnt_load),
    .dec_i      (state_q == MD_BUSY),
    .done_o     (cnt_done)
  );

  // FSM, HI/LO and pending result. Any start seen while BUSY is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            state_q   <= MD_BUSY;
            busy_q    <= 1'b1;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
          end else if (start && (md_op == MD_MTHI)) begin
            hi_q <= a;
          end else if (start && (md_op == MD_MTLO)) begin
            lo_q <= a;
          end
        end
        MD_BUSY: begin
          if (cnt_done) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign stall = d_is_md & (busy_q | (start & md_is_long(md_op)));

  always_comb begin
    out = '0;
    case (md_op)
      MD_MFHI: out = hi_q;
      MD_MFLO: out = lo_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit. Expected HI/LO pairs come
// from a behavioural model (64-bit integer arithmetic) and are queued when
// an operation is issued, then popped and compared once busy drops.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] a, b;
  logic        d_is_md;
  logic        busy, stall;
  logic [31:0] out;

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .start   (start),
    .a       (a),
    .b       (b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall   (stall),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } hl_t;

  hl_t         sb_q[$];
  logic [31:0] hi_m, lo_m;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: updates hi_m/lo_m and queues the expected pair.
  task automatic model_push(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, ua, ub, acc, r;
    hl_t    e;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ua  = longint'(av);
    ub  = longint'(bv);
    acc = longint'({hi_m, lo_m});
    r   = acc;
    case (op)
      MD_MULT:  r = sa * sb;
      MD_MULTU: r = ua * ub;
      MD_DIV:   if (bv != 0) r = longint'({32'(sa % sb), 32'(sa / sb)});
      MD_DIVU:  if (bv != 0) r = longint'({32'(ua % ub), 32'(ua / ub)});
      MD_MADD:  r = acc + sa * sb;
      MD_MADDU: r = acc + ua * ub;
      MD_MSUB:  r = acc - sa * sb;
      MD_MSUBU: r = acc - ua * ub;
      default:  r = acc;
    endcase
    hi_m = r[63:32];
    lo_m = r[31:0];
    e.hi = hi_m;
    e.lo = lo_m;
    sb_q.push_back(e);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    md_op = MD_MFHI;
    #1 check_eq({tag, "_hi"}, out, ehi);
    md_op = MD_MFLO;
    #1 check_eq({tag, "_lo"}, out, elo);
    md_op = MD_NONE;
  endtask

  // Issue a long op, track busy length and stall, then check HI/LO.
  // poke: try an MTHI during the first busy cycle (must be ignored).
  task automatic do_long(input string tag, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input int ncyc, input bit poke);
    int  cnt;
    hl_t e;
    model_push(op, av, bv);
    start = 1'b1;
    md_op = op;
    a     = av;
    b     = bv;
    #1 check_eq({tag, "_stall_acc"}, 32'(stall), 32'(d_is_md));
    check_eq({tag, "_busy_acc"}, 32'(busy), 32'd0);
    tick();
    cnt = 0;
    while (busy && cnt < 40) begin
      if (poke && cnt == 0) begin
        start = 1'b1;
        md_op = MD_MTHI;
        a     = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
        md_op = MD_NONE;
      end
      #1 check_eq({tag, "_stall_busy"}, 32'(stall), 32'(d_is_md));
      cnt++;
      tick();
    end
    start = 1'b0;
    md_op = MD_NONE;
    check_eq({tag, "_busy_len"}, 32'(cnt), 32'(ncyc));
    #1 check_eq({tag, "_stall_done"}, 32'(stall), 32'd0);
    e = sb_q.pop_front();
    read_hilo(tag, e.hi, e.lo);
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] val);
    start = 1'b1;
    md_op = op;
    a     = val;
    tick();
    start = 1'b0;
    md_op = MD_NONE;
    if (op == MD_MTHI) hi_m = val;
    else lo_m = val;
    check_eq("mt_busy", 32'(busy), 32'd0);
    read_hilo("mt", hi_m, lo_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset   = 1'b1;
    start   = 1'b0;
    md_op   = MD_NONE;
    a       = '0;
    b       = '0;
    d_is_md = 1'b1;
    hi_m    = '0;
    lo_m    = '0;
    repeat (2) tick();
    reset = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    // Directed cases; stall tracked with d_is_md=1 then 0.
    do_long("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 5, 1'b0);
    d_is_md = 1'b0;
    do_long("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
    d_is_md = 1'b1;
    do_long("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 1'b0);
    do_long("divu",  MD_DIVU,  32'd7,         32'd2, 10, 1'b0);
    do_long("div0",  MD_DIV,   32'd7,         32'd0, 10, 1'b0);
    do_long("divu0", MD_DIVU,  32'd9,         32'd0, 10, 1'b0);
    do_long("divmin", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
    do_long("divneg", MD_DIV,  32'd7,         32'hFFFF_FFFE, 10, 1'b0);

    do_mt(MD_MTHI, 32'h1234_5678);
    do_mt(MD_MTLO, 32'hCAFE_F00D);

    // Start while busy must not disturb the pending commit.
    do_long("poke", MD_MULT, 32'd3, 32'd5, 5, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rop = 4'(1 + $urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd1 : $urandom;
      d_is_md = 1'($urandom_range(0, 1));
      do_long("rand", rop, ra, rb, md_is_div(rop) ? 10 : 5, 1'b0);
    end
    d_is_md = 1'b1;

    // Reset in the middle of a divide discards the pending result.
    start = 1'b1;
    md_op = MD_DIV;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    start = 1'b0;
    md_op = MD_NONE;
    repeat (3) tick();
    check_eq("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi_m  = '0;
    lo_m  = '0;
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    read_hilo("rst_mid", 32'd0, 32'd0);
    repeat (12) tick();
    check_eq("rst_late_busy", 32'(busy), 32'd0);
    read_hilo("rst_late", 32'd0, 32'd0);

`ifdef MD_MADD_EN
    do_mt(MD_MTHI, 32'd0);
    do_mt(MD_MTLO, 32'd5);
    do_long("madd",  MD_MADD,  32'd3, 32'd4, 5, 1'b0);
    do_long("msub",  MD_MSUB,  32'd10, 32'd2, 5, 1'b0);
    do_long("maddu", MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
    do_long("msubu", MD_MSUBU, 32'hFFFF_FFFF, 32'd3, 5, 1'b0);
`else
    // Without the feature the madd family behaves as NONE.
    start = 1'b1;
    md_op = MD_MADD;
    a     = 32'd3;
    b     = 32'd4;
    #1 check_eq("madd_off_stall", 32'(stall), 32'd0);
    tick();
    start = 1'b0;
    md_op = MD_NONE;
    check_eq("madd_off_busy", 32'(busy), 32'd0);
    read_hilo("madd_off", hi_m, lo_m);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
